// File: rtl/ascon_seq_ctrl.sv
// Sequencer between a parallel requester and the bit-serial ASCON core:
// latches a request, resets and loads the core serially, starts it, then collects data/tag.
module ascon_seq_ctrl #(
  parameter int KEY_W        = 128,
  parameter int NONCE_W      = 128,
  parameter int AD_W         = 40,
  parameter int DATA_W       = 104,
  parameter int TAG_W        = 128,
  parameter int CRST_CYCLES  = 2,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_decrypt_i,
  input  logic [KEY_W-1:0]   key_i,
  input  logic [NONCE_W-1:0] nonce_i,
  input  logic [AD_W-1:0]    ad_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic               core_rst_o,
  output logic               core_key_o,
  output logic               core_nonce_o,
  output logic               core_ad_o,
  output logic               core_data_o,
  output logic               core_start_o,
  output logic               core_decrypt_o,
  input  logic               core_data_i,
  input  logic               core_tag_i,
  input  logic               core_ready_i,
  output logic               busy_o,
  output logic               res_valid_o,
  output logic [DATA_W-1:0]  res_data_o,
  output logic [TAG_W-1:0]   res_tag_o,
  output logic               res_timeout_o
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int LOAD_N  = max2(max2(KEY_W, NONCE_W), max2(AD_W, DATA_W));
  localparam int READ_N  = max2(DATA_W, TAG_W);
  localparam int CNT_MAX = max2(max2(LOAD_N, READ_N), max2(TIMEOUT, max2(CRST_CYCLES, START_CYCLES)));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CRST_LAST  = CNT_W'(CRST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_N - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_N - 1);
  localparam logic [CNT_W-1:0] DATA_N     = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] TAG_N      = CNT_W'(TAG_W);

  // IDLE accept | CRST core reset | LOAD shift fields | START | WAIT ready | READ collect | DONE strobe
  typedef enum logic [2:0] {
    S_IDLE, S_CRST, S_LOAD, S_START, S_WAIT, S_READ, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   key_sr_q;
  logic [NONCE_W-1:0] nonce_sr_q;
  logic [AD_W-1:0]    ad_sr_q;
  logic [DATA_W-1:0]  data_sr_q;
  logic               dec_q;
  logic [DATA_W-1:0]  res_data_q;
  logic [TAG_W-1:0]   res_tag_q;
  logic               timeout_q;
  logic               accept;
  logic               timed_out;

  assign accept    = (state_q == S_IDLE) && req_valid_i;
  assign timed_out = (state_q == S_WAIT) && !core_ready_i && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_valid_i) state_d = S_CRST;
      S_CRST:  if (cnt_q == CRST_LAST) state_d = S_LOAD;
      S_LOAD:  if (cnt_q == LOAD_LAST) state_d = S_START;
      S_START: if (cnt_q == START_LAST) state_d = S_WAIT;
      S_WAIT: begin
        if (core_ready_i)          state_d = S_READ;
        else if (cnt_q == TO_LAST) state_d = S_DONE;
      end
      S_READ:  if (cnt_q == READ_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One shared counter: every state leaves on its own terminal count, so it never wraps.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if ((state_d != state_q) || (state_q == S_IDLE)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      key_sr_q   <= '0;
      nonce_sr_q <= '0;
      ad_sr_q    <= '0;
      data_sr_q  <= '0;
      dec_q      <= 1'b0;
      res_data_q <= '0;
      res_tag_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        key_sr_q   <= key_i;
        nonce_sr_q <= nonce_i;
        ad_sr_q    <= ad_i;
        data_sr_q  <= data_i;
        dec_q      <= req_decrypt_i;
        timeout_q  <= 1'b0;
      end else if (state_q == S_LOAD) begin
        // Zero fill makes shorter fields drive 0 once exhausted.
        key_sr_q   <= {key_sr_q[KEY_W-2:0], 1'b0};
        nonce_sr_q <= {nonce_sr_q[NONCE_W-2:0], 1'b0};
        ad_sr_q    <= {ad_sr_q[AD_W-2:0], 1'b0};
        data_sr_q  <= {data_sr_q[DATA_W-2:0], 1'b0};
      end
      if (state_q == S_READ) begin
        // Right shift: after W samples, sample j lands in bit j.
        if (cnt_q < DATA_N) res_data_q <= {core_data_i, res_data_q[DATA_W-1:1]};
        if (cnt_q < TAG_N)  res_tag_q  <= {core_tag_i, res_tag_q[TAG_W-1:1]};
      end
      if (timed_out) begin
        timeout_q  <= 1'b1;
        res_data_q <= '0;
        res_tag_q  <= '0;
      end
    end
  end

  always_comb begin
    req_ready_o    = (state_q == S_IDLE);
    busy_o         = (state_q != S_IDLE);
    core_rst_o     = (state_q == S_CRST);
    core_start_o   = (state_q == S_START);
    core_key_o     = (state_q == S_LOAD) && key_sr_q[KEY_W-1];
    core_nonce_o   = (state_q == S_LOAD) && nonce_sr_q[NONCE_W-1];
    core_ad_o      = (state_q == S_LOAD) && ad_sr_q[AD_W-1];
    core_data_o    = (state_q == S_LOAD) && data_sr_q[DATA_W-1];
    core_decrypt_o = dec_q;
    res_valid_o    = (state_q == S_DONE);
    res_data_o     = res_data_q;
    res_tag_o      = res_tag_q;
    res_timeout_o  = timeout_q;
  end

endmodule

// File: tb/tb_ascon_seq_ctrl.sv
// Randomised bench for ascon_seq_ctrl: stub core plus a timeline model of each
// transaction (relative cycle numbers) checked against the DUT every cycle.
module tb_ascon_seq_ctrl;
  localparam int KEY_W = 128, NONCE_W = 128, AD_W = 40, DATA_W = 104, TAG_W = 128;
  localparam int CRST = 2, START = 2, T = 16;
  localparam int LOAD_N = 128, READ_N = 128;
  localparam int LOAD_REL  = 1 + CRST;
  localparam int START_REL = LOAD_REL + LOAD_N;
  localparam int WAIT_REL  = START_REL + START;

  localparam logic [127:0] K0 = 128'h6d4f8bbf60ec05a07b201d4e5b2119ac;
  localparam logic [127:0] N0 = 128'h05885e606e1271b8d47a74c7b297a318;
  localparam logic [39:0]  A0 = 40'h4153434f4e;
  localparam logic [103:0] D0 = 104'h6173636f6e2d756e6963617373;

  logic clk = 1'b0;
  logic rst, req_valid_i, req_ready_o, req_decrypt_i;
  logic [KEY_W-1:0] key_i;
  logic [NONCE_W-1:0] nonce_i;
  logic [AD_W-1:0] ad_i;
  logic [DATA_W-1:0] data_i;
  logic core_rst_o, core_key_o, core_nonce_o, core_ad_o, core_data_o;
  logic core_start_o, core_decrypt_o, core_data_i, core_tag_i, core_ready_i;
  logic busy_o, res_valid_o, res_timeout_o;
  logic [DATA_W-1:0] res_data_o;
  logic [TAG_W-1:0] res_tag_o;

  always #5 clk = ~clk;

  ascon_seq_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_decrypt_i(req_decrypt_i), .key_i(key_i), .nonce_i(nonce_i), .ad_i(ad_i),
    .data_i(data_i), .core_rst_o(core_rst_o), .core_key_o(core_key_o),
    .core_nonce_o(core_nonce_o), .core_ad_o(core_ad_o), .core_data_o(core_data_o),
    .core_start_o(core_start_o), .core_decrypt_o(core_decrypt_o),
    .core_data_i(core_data_i), .core_tag_i(core_tag_i), .core_ready_i(core_ready_i),
    .busy_o(busy_o), .res_valid_o(res_valid_o), .res_data_o(res_data_o),
    .res_tag_o(res_tag_o), .res_timeout_o(res_timeout_o)
  );

  int n_chk = 0, n_fail = 0;

  // plan for the next request (set by the driver before raising req_valid_i)
  int p_w;
  bit p_to;
  logic [READ_N-1:0] p_d, p_t;

  // model of the transaction in flight
  bit m_active = 1'b0, chk_en = 1'b0;
  int m_rel = 0, m_w = 0;
  bit m_to = 1'b0;
  logic [KEY_W-1:0] m_key;
  logic [NONCE_W-1:0] m_nonce;
  logic [AD_W-1:0] m_ad;
  logic [DATA_W-1:0] m_data;
  logic [READ_N-1:0] m_d, m_t;
  logic [DATA_W-1:0] exp_data = '0;
  logic [TAG_W-1:0] exp_tag = '0;
  logic exp_to = 1'b0, exp_dec = 1'b0;

  // recorders for the directed literal checks
  logic [LOAD_N-1:0] rec_key, rec_nonce, rec_ad, rec_dat;
  int rst_n, rst_first, rst_last, st_n, st_first, st_last, v_n, v_rel;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (rel %0d): got %h expected %h", name, m_rel, act, exp);
    end
  endtask

  function automatic int done_rel();
    return m_to ? (WAIT_REL + T) : (WAIT_REL + 1 + m_w + READ_N);
  endfunction

  function automatic bit in_read();
    return m_active && !m_to && (m_rel >= WAIT_REL + 1 + m_w) && (m_rel < WAIT_REL + 1 + m_w + READ_N);
  endfunction

  // compare + model update, once per cycle at the falling edge
  initial begin
    int i;
    bit ld;
    logic e_key, e_nonce, e_ad, e_data;
    logic [10:0] e_vec, a_vec;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (m_active && m_rel == done_rel()) begin
          if (m_to) begin exp_data = '0; exp_tag = '0; exp_to = 1'b1; end
          else begin exp_data = m_d[DATA_W-1:0]; exp_tag = m_t[TAG_W-1:0]; end
        end
        ld = m_active && m_rel >= LOAD_REL && m_rel < START_REL;
        i = m_rel - LOAD_REL;
        e_key = 1'b0; e_nonce = 1'b0; e_ad = 1'b0; e_data = 1'b0;
        if (ld && i < KEY_W)   e_key   = m_key[KEY_W-1-i];
        if (ld && i < NONCE_W) e_nonce = m_nonce[NONCE_W-1-i];
        if (ld && i < AD_W)    e_ad    = m_ad[AD_W-1-i];
        if (ld && i < DATA_W)  e_data  = m_data[DATA_W-1-i];
        e_vec = {!m_active, m_active,
                 m_active && m_rel >= 1 && m_rel < LOAD_REL,
                 m_active && m_rel >= START_REL && m_rel < WAIT_REL,
                 e_key, e_nonce, e_ad, e_data, exp_dec,
                 m_active && m_rel == done_rel(), exp_to};
        a_vec = {req_ready_o, busy_o, core_rst_o, core_start_o, core_key_o, core_nonce_o,
                 core_ad_o, core_data_o, core_decrypt_o, res_valid_o, res_timeout_o};
        check("ctrl_vec", a_vec, e_vec);
        if (!in_read()) begin
          check("res_data", res_data_o, exp_data);
          check("res_tag", res_tag_o, exp_tag);
        end
        if (ld) begin
          rec_key[LOAD_N-1-i] = core_key_o;
          rec_nonce[LOAD_N-1-i] = core_nonce_o;
          rec_ad[LOAD_N-1-i] = core_ad_o;
          rec_dat[LOAD_N-1-i] = core_data_o;
        end
        if (core_rst_o === 1'b1) begin rst_n++; if (rst_first < 0) rst_first = m_rel; rst_last = m_rel; end
        if (core_start_o === 1'b1) begin st_n++; if (st_first < 0) st_first = m_rel; st_last = m_rel; end
        if (res_valid_o === 1'b1) begin v_n++; v_rel = m_rel; end
      end
      if (rst) begin
        m_active = 1'b0; exp_data = '0; exp_tag = '0; exp_to = 1'b0; exp_dec = 1'b0; chk_en = 1'b1;
      end else if (m_active) begin
        if (m_rel == done_rel()) m_active = 1'b0;
        else m_rel++;
      end else if (chk_en && req_valid_i) begin
        m_active = 1'b1; m_rel = 1;
        m_key = key_i; m_nonce = nonce_i; m_ad = ad_i; m_data = data_i;
        m_w = p_w; m_to = p_to; m_d = p_d; m_t = p_t;
        exp_to = 1'b0; exp_dec = req_decrypt_i;
      end
    end
  end

  // stub core: ready timing and READ streams follow the plan, random elsewhere
  initial begin
    int j;
    core_ready_i = 1'b0; core_data_i = 1'b0; core_tag_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      core_ready_i = 1'($urandom % 2);
      core_data_i = 1'($urandom % 2);
      core_tag_i = 1'($urandom % 2);
      if (m_active && m_rel >= WAIT_REL) begin
        if (m_rel < WAIT_REL + (m_to ? T : m_w)) core_ready_i = 1'b0;
        else if (!m_to && m_rel == WAIT_REL + m_w) core_ready_i = 1'b1;
        if (in_read()) begin
          j = m_rel - (WAIT_REL + 1 + m_w);
          core_data_i = m_d[j];
          core_tag_i = m_t[j];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clr_rec();
    rst_n = 0; rst_first = -1; rst_last = -1;
    st_n = 0; st_first = -1; st_last = -1;
    v_n = 0; v_rel = -1;
    rec_key = '0; rec_nonce = '0; rec_ad = '0; rec_dat = '0;
  endtask

  task automatic run_txn(input logic [127:0] k, input logic [127:0] n, input logic [39:0] a,
                         input logic [103:0] d, input bit dec, input int w, input bit to,
                         input bit noise, input int rst_at);
    int nw;
    bit stop;
    key_i = k; nonce_i = n; ad_i = a; data_i = d; req_decrypt_i = dec;
    p_w = w; p_to = to;
    req_valid_i = 1'b1;
    nw = 0;
    step();
    while (!m_active && nw < 20) begin step(); nw++; end
    if (nw >= 20) check("accept_bound", 0, 1);
    req_valid_i = 1'b0;
    nw = 0; stop = 1'b0;
    while (m_active && !stop && nw < 1000) begin
      if (rst_at > 0 && m_rel == rst_at) begin
        rst = 1'b1; req_valid_i = 1'b1;
        step();
        rst = 1'b0; req_valid_i = 1'b0;
        check("rst_ctrl", {req_ready_o, busy_o, core_rst_o, core_start_o, core_key_o, core_nonce_o,
                           core_ad_o, core_data_o, core_decrypt_o, res_valid_o, res_timeout_o},
              11'b10000000000);
        check("rst_res", {res_data_o, res_tag_o[23:0]}, '0);
        stop = 1'b1;
      end else begin
        if (noise && m_rel < START_REL - 2) req_valid_i = 1'($urandom % 2);
        else req_valid_i = 1'b0;
        step();
        nw++;
      end
    end
    req_valid_i = 1'b0;
    if (nw >= 1000) check("done_bound", 0, 1);
  endtask

  initial begin
    int gap;
    rst = 1'b1; req_valid_i = 1'b0; req_decrypt_i = 1'b0;
    key_i = '0; nonce_i = '0; ad_i = '0; data_i = '0;
    p_w = 0; p_to = 1'b0; p_d = '0; p_t = '0;
    clr_rec();
    repeat (3) step();
    check("reset_ctrl", {req_ready_o, busy_o, core_rst_o, core_start_o, core_decrypt_o,
                         res_valid_o, res_timeout_o}, 7'b1000000);
    check("reset_res", res_data_o | res_tag_o[103:0], '0);
    rst = 1'b0;
    step();

    // stub core with ready already high at WAIT entry
    clr_rec();
    p_d = {$urandom, $urandom, $urandom, $urandom};
    p_t = {$urandom, $urandom, $urandom, $urandom};
    run_txn(K0, N0, A0, D0, 1'b0, 0, 1'b0, 1'b0, 0);
    check("crst_pulse", {rst_n[7:0], rst_first[9:0], rst_last[9:0]}, {8'd2, 10'd1, 10'd2});
    check("start_pulse", {st_n[7:0], st_first[9:0], st_last[9:0]}, {8'd2, 10'd131, 10'd132});
    check("valid_at", {v_n[7:0], v_rel[9:0]}, {8'd1, 10'd262});
    check("key_stream", rec_key, K0);
    check("nonce_stream", rec_nonce, N0);
    check("ad_stream", rec_ad, {A0, 88'b0});
    check("data_stream", rec_dat, {D0, 24'b0});
    check("res_data1", res_data_o, p_d[103:0]);
    check("timeout1", res_timeout_o, 0);

    // data line all ones, tag zero, ready after 5 WAIT cycles, second request during LOAD
    clr_rec();
    p_d = '1; p_t = '0;
    run_txn(K0, N0, A0, 104'h18490112f8d5867a830748390b, 1'b1, 5, 1'b0, 1'b1, 0);
    check("valid_once", {v_n[7:0], v_rel[9:0]}, {8'd1, 10'd267});
    check("ones_data", res_data_o, {104{1'b1}});
    check("zero_tag", res_tag_o, 128'd0);
    check("decrypt_held", core_decrypt_o, 1);

    // ready never comes
    clr_rec();
    run_txn(K0, N0, A0, D0, 1'b0, 0, 1'b1, 1'b0, 0);
    check("to_valid_at", {v_n[7:0], v_rel[9:0]}, {8'd1, 10'd149});
    check("to_flag", {res_timeout_o, res_data_o, res_tag_o[23:0]}, {1'b1, 128'd0});

    // reset in the middle of LOAD, request presented together with reset
    clr_rec();
    run_txn({$urandom, $urandom, $urandom, $urandom}, N0, A0, D0, 1'b1, 2, 1'b0, 1'b0, 50);
    check("rst_no_valid", v_n, 0);
    step();
    check("rst_drop", busy_o, 0);

    // randomised traffic, including back-to-back requests
    for (int t = 0; t < 20; t++) begin
      p_d = {$urandom, $urandom, $urandom, $urandom};
      p_t = {$urandom, $urandom, $urandom, $urandom};
      run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
              {8'($urandom), $urandom}, {8'($urandom), $urandom, $urandom, $urandom},
              1'($urandom % 2), int'($urandom_range(0, T - 1)), ($urandom % 5) == 0,
              1'($urandom % 2), 0);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step();
    end
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
